// File: rtl/divmul_pkg.sv
// Shared definitions for the 16x8 multiply-add reconstruction block.
// QW/BW/PW are the quotient/remainder, divisor and product widths.
// divmul_res_t is the result bundle that downstream checkers consume.
package divmul_pkg;
  localparam int QW = 16;
  localparam int BW = 8;
  localparam int PW = QW + BW;
  localparam int CW = $clog2(QW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divmul_state_e;

  typedef struct packed {
    logic [PW-1:0] product;
    logic          ovf;
    logic          rem_err;
    logic          div_zero;
  } divmul_res_t;
endpackage

// File: rtl/divmul_step.sv
// One LSB-first shift-add iteration.
//   acc_i/mcand_i : current accumulator and shifted multiplicand
//   qbit_i        : current quotient bit (LSB of the remaining quotient)
//   acc_o/mcand_o : next accumulator and multiplicand
// The add cannot overflow PW bits for legal 16x8 operands plus a 16-bit R.
module divmul_step
  import divmul_pkg::*;
(
  input  logic [PW-1:0] acc_i,
  input  logic [PW-1:0] mcand_i,
  input  logic          qbit_i,
  output logic [PW-1:0] acc_o,
  output logic [PW-1:0] mcand_o
);
  always_comb begin
    acc_o   = qbit_i ? (acc_i + mcand_i) : acc_i;
    mcand_o = mcand_i << 1;
  end
endmodule

// File: rtl/divmul_16x8_seq.sv
// Sequential reconstruction of a 16/8 division: product = Q*B + R.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (q, b, r sampled on accept)
//   out_valid/out_ready : result handshake
//   product             : Q*B + R (PW bits)
//   ovf                 : product does not fit a 16-bit dividend
//   rem_err             : R >= B
//   div_zero            : B == 0
// Always 16 RUN cycles per operation; outputs are a registered result
// that reads zero outside DONE.
module divmul_16x8_seq
  import divmul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] q,
  input  logic [BW-1:0] b,
  input  logic [QW-1:0] r,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] product,
  output logic          ovf,
  output logic          rem_err,
  output logic          div_zero
);
  divmul_state_e state_q, state_d;
  logic [PW-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [QW-1:0] qsh_q, qsh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Flags captured at accept, published only when the result is.
  logic          rem_err_pend_q, rem_err_pend_d;
  logic          div_zero_pend_q, div_zero_pend_d;
  divmul_res_t   res_q, res_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] acc_step, mcand_step;

  divmul_step u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .qbit_i  (qsh_q[0]),
    .acc_o   (acc_step),
    .mcand_o (mcand_step)
  );

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    mcand_d         = mcand_q;
    qsh_d           = qsh_q;
    cnt_d           = cnt_q;
    rem_err_pend_d  = rem_err_pend_q;
    div_zero_pend_d = div_zero_pend_q;
    res_d           = res_q;
    in_ready_d      = in_ready_q;
    out_valid_d     = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          acc_d           = PW'(r);
          mcand_d         = PW'(b);
          qsh_d           = q;
          cnt_d           = '0;
          rem_err_pend_d  = (r >= QW'(b));
          div_zero_pend_d = (b == '0);
          in_ready_d      = 1'b0;
          state_d         = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_step;
        mcand_d = mcand_step;
        qsh_d   = qsh_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(QW-1)) begin
          // Last iteration: publish the post-add value directly.
          res_d.product  = acc_step;
          res_d.ovf      = |acc_step[PW-1:QW];
          res_d.rem_err  = rem_err_pend_q;
          res_d.div_zero = div_zero_pend_q;
          out_valid_d    = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          res_d       = '0;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        res_d       = '0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      acc_q           <= '0;
      mcand_q         <= '0;
      qsh_q           <= '0;
      cnt_q           <= '0;
      rem_err_pend_q  <= 1'b0;
      div_zero_pend_q <= 1'b0;
      res_q           <= '0;
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      mcand_q         <= mcand_d;
      qsh_q           <= qsh_d;
      cnt_q           <= cnt_d;
      rem_err_pend_q  <= rem_err_pend_d;
      div_zero_pend_q <= div_zero_pend_d;
      res_q           <= res_d;
      in_ready_q      <= in_ready_d;
      out_valid_q     <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = res_q.product;
  assign ovf       = res_q.ovf;
  assign rem_err   = res_q.rem_err;
  assign div_zero  = res_q.div_zero;
endmodule

// File: tb/tb_divmul_16x8_seq.sv
module tb_divmul_16x8_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] q;
  logic [7:0]  b;
  logic [15:0] r;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] product;
  logic        ovf, rem_err, div_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divmul_16x8_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .b(b), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .ovf(ovf), .rem_err(rem_err), .div_zero(div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All stimulus changes and samples happen on the falling edge.
  task automatic run_op(input logic [15:0] qi, input logic [7:0] bi,
                        input logic [15:0] ri, input int stall,
                        input logic [23:0] ep, input logic eo,
                        input logic ere, input logic edz);
    logic quiet, stable;
    logic [23:0] p0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    q = qi; b = bi; r = ri; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);                    // accept edge passed
    in_valid = 1'b0;
    q = 16'hDEAD; b = 8'hA5; r = 16'h5A5A;   // must not matter any more
    quiet = (in_ready == 1'b0) && (out_valid == 1'b0) && (product == '0);
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || product !== '0 ||
          ovf !== 1'b0 || rem_err !== 1'b0 || div_zero !== 1'b0)
        quiet = 1'b0;
    end
    chk("run_quiet", 32'(quiet), 32'd1);
    @(negedge clk);                    // 16 cycles after accept
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("in_ready_done", 32'(in_ready), 32'd0);
    chk("product", 32'(product), 32'(ep));
    chk("flags", {29'd0, ovf, rem_err, div_zero}, {29'd0, eo, ere, edz});
    p0 = product;
    stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || product !== p0 || ovf !== eo ||
          rem_err !== ere || div_zero !== edz || in_ready !== 1'b0)
        stable = 1'b0;
    end
    if (stall > 0) chk("stall_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);                    // output handshake passed
    out_ready = 1'b0;
    chk("post_hs", {29'd0, out_valid, in_ready, |product}, {29'd0, 1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; q = '0; b = '0; r = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_state", {24'd0, in_ready, out_valid, ovf, rem_err, div_zero, 3'd0},
                     {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
    chk("rst_product", 32'(product), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 255*255 + 254
    run_op(16'h00FF, 8'hFF, 16'h00FE, 0, 24'h00FEFF, 1'b0, 1'b0, 1'b0);
    // maximum operands
    run_op(16'hFFFF, 8'hFF, 16'hFFFF, 0, 24'hFFFF00, 1'b1, 1'b1, 1'b0);
    // divide by zero still completes, product = R
    run_op(16'h1234, 8'h00, 16'h0005, 0, 24'h000005, 1'b0, 1'b1, 1'b1);
    // stalled consumer, operands disturbed after accept
    run_op(16'h1234, 8'h56, 16'h0021, 10, 24'h061D99, 1'b1, 1'b0, 1'b0);
    // Q == 0
    run_op(16'h0000, 8'h07, 16'h0003, 0, 24'h000003, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of RUN aborts the operation.
    begin
      logic saw_valid;
      q = 16'hABCD; b = 8'h12; r = 16'h0003; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 1; k < 7; k++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_state", {27'd0, in_ready, out_valid, ovf, rem_err, div_zero},
                         {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      chk("abort_product", 32'(product), 32'd0);
      saw_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (out_valid !== 1'b0) saw_valid = 1'b1;
      end
      out_ready = 1'b0;
      chk("abort_no_result", 32'(saw_valid), 32'd0);
    end
    run_op(16'h0002, 8'h03, 16'h0001, 0, 24'h000007, 1'b0, 1'b0, 1'b0);

    // Closed loop through a golden divide with random throttling.
    for (int v = 0; v < 300; v++) begin
      logic [15:0] a, qq, rr;
      logic [7:0]  bb;
      int waited;
      a  = 16'($urandom);
      bb = 8'($urandom_range(1, 255));
      qq = a / 16'(bb);
      rr = a % 16'(bb);
      for (int d = $urandom_range(0, 3); d > 0; d--) @(negedge clk);
      q = qq; b = bb; r = rr; in_valid = 1'b1;
      waited = 0;
      while (in_ready !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
      @(negedge clk);
      in_valid = 1'b0;
      waited = 0;
      while (out_valid !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
      chk("rand_done", 32'(out_valid), 32'd1);
      for (int d = $urandom_range(0, 3); d > 0; d--) @(negedge clk);
      chk("rand_product", 32'(product), 32'(a));
      chk("rand_flags", {29'd0, ovf, rem_err, div_zero}, 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
